instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the instruction address width.
REQ-002 The block SHALL have parameter PROG_LEN, default 2, meaning the number of instructions executed per run, from address 0 to PROG_LEN-1.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the I2C completion watchdog limit.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; ports SHALL be clk (in, 1) and reset_n (in, 1).
REQ-005 Port start, in, 1: run request pulse.
REQ-006 Port reg_addr, out, ADDR_W: instruction address to register memory.
REQ-007 Port read_data, in, 32: instruction word, valid one cycle after reg_addr.
REQ-008 Port error_code, in, 4: memory error; nonzero means invalid address.
REQ-009 Ports i2c_valid (out, 1) and i2c_ready (in, 1): request handshake.
REQ-010 Ports i2c_rw (out, 1, 1=read), i2c_dev (out, 8), i2c_reg (out, 8) and i2c_wdata (out, 8): request fields.
REQ-011 Ports i2c_done (in, 1), i2c_ack_err (in, 1) and i2c_rdata (in, 8): transaction completion, NACK flag and read byte.
REQ-012 Ports rd_valid (out, 1) and rd_data (out, 8): read result strobe and byte.
REQ-013 Ports busy (out, 1), done (out, 1), fault (out, 1) and fault_code (out, 4): status.

Function
REQ-014 Instruction format SHALL be op [31:24], dev [23:16], reg [15:8], data [7:0]; op 0x00 is NOP, 0x01 is I2C read, 0x02 is I2C write.
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, ISSUE, WAIT_DONE and FAULT.
REQ-016 reg_addr SHALL be driven directly from the program counter register pc.
REQ-017 In IDLE or FAULT, start=1 SHALL set pc=0, clear fault and fault_code, and go to FETCH; start SHALL be ignored in every other state.
REQ-018 FETCH SHALL last exactly 1 cycle and then go to DECODE, where read_data and error_code are sampled.
REQ-019 In DECODE, a nonzero error_code SHALL go to FAULT with fault_code=1; this check SHALL take priority over op decode.
REQ-020 In DECODE, op 0x00 SHALL advance; op 0x01 or 0x02 SHALL latch the fields and go to ISSUE; any other op SHALL go to FAULT with fault_code=2.
REQ-021 In ISSUE, i2c_valid SHALL be 1 and the request fields SHALL be held stable until the cycle with i2c_valid&&i2c_ready, after which the FSM goes to WAIT_DONE.
REQ-022 i2c_rw SHALL be 1 for op 0x01; i2c_wdata SHALL be the data field for op 0x02.
REQ-023 In WAIT_DONE, i2c_done with i2c_ack_err=1 SHALL go to FAULT with fault_code=3.
REQ-024 In WAIT_DONE, i2c_done with i2c_ack_err=0 SHALL advance; for a read, rd_valid SHALL pulse for 1 cycle with rd_data=i2c_rdata.
REQ-025 When pc<PROG_LEN-1, advance SHALL increment pc and go to FETCH.
REQ-026 When pc==PROG_LEN-1, advance SHALL go to IDLE, pulse done for 1 cycle, and leave pc unchanged; pc never wraps within a run.
REQ-027 busy SHALL be 1 in FETCH, DECODE, ISSUE and WAIT_DONE, and 0 otherwise.
REQ-028 fault SHALL be 1 only in FAULT, and fault_code SHALL be held until the next start.
REQ-029 i2c_done seen outside WAIT_DONE SHALL be ignored.

Reset
REQ-030 On reset_n=0, asynchronously, the state SHALL go to IDLE and pc, reg_addr, i2c_valid, i2c_rw, i2c_dev, i2c_reg, i2c_wdata, rd_valid, rd_data, busy, done, fault and fault_code SHALL all be 0.
REQ-031 Reset during ISSUE or WAIT_DONE SHALL abandon the transaction without further handshake; reset release SHALL be synchronised to clk.

Configuration
REQ-032 Macro SEQ_TIMEOUT_EN defined: a counter SHALL be cleared on entry to WAIT_DONE and incremented each WAIT_DONE cycle; reaching TIMEOUT_CYCLES without i2c_done SHALL go to FAULT with fault_code=4.
REQ-033 Macro SEQ_TIMEOUT_EN undefined: WAIT_DONE SHALL wait indefinitely, no counter logic SHALL exist, and fault_code=4 SHALL never occur.

Verification
REQ-034 Memory {0x0100f000, 0x021dab32}, ready=1, done 3 cycles after each accept, rdata 0x5A -> read dev 0x00 reg 0xF0, rd_data=0x5A, then write dev 0x1D reg 0xAB wdata 0x32, done pulses, busy=0.
REQ-035 i2c_ready held 0 for 5 cycles -> i2c_valid and all fields stable for those 5 cycles, exactly one accept.
REQ-036 error_code=1 at pc 1 -> fault=1, fault_code=1, no second request; a following start restarts at pc=0.
REQ-037 Op 0x07 -> fault_code=2; i2c_ack_err on the write -> fault_code=3; start pulsed while busy -> ignored.
REQ-038 reset_n asserted in WAIT_DONE -> all outputs 0 immediately; with SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no done -> fault_code=4 after 16 cycles.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches PROG_LEN words from register memory and issues I2C reads/writes.
// Optional I2C completion watchdog enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned PROG_LEN       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       read_data,
  input  logic [3:0]        error_code,
  output logic              i2c_valid,
  input  logic              i2c_ready,
  output logic              i2c_rw,
  output logic [7:0]        i2c_dev,
  output logic [7:0]        i2c_reg,
  output logic [7:0]        i2c_wdata,
  input  logic              i2c_done,
  input  logic              i2c_ack_err,
  input  logic [7:0]        i2c_rdata,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [3:0]        fault_code
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StIssue, StWaitDone, StFault
  } state_e;

  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(PROG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rw_q, rw_d;
  logic [7:0]        dev_q, dev_d, reg_q, reg_d, wdata_q, wdata_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d, done_q, done_d;
  logic [3:0]        fault_code_q, fault_code_d;
  logic              advance;
  logic              tmo_hit;
  logic [1:0]        rst_sync_q;
  logic              rst_int_n;

  // Assert asynchronously, release two clocks later in the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                tmo_cnt_q <= '0;
    else if (state_q == StIssue)   tmo_cnt_q <= '0;
    else if (state_q == StWaitDone) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
  assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rw_d         = rw_q;
    dev_d        = dev_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    fault_code_d = fault_code_q;
    advance      = 1'b0;
    unique case (state_q)
      StIdle, StFault: begin
        if (start) begin
          pc_d         = '0;
          fault_code_d = 4'd0;
          state_d      = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (error_code != 4'd0) begin
          fault_code_d = 4'd1;
          state_d      = StFault;
        end else begin
          case (read_data[31:24])
            8'h00: advance = 1'b1;
            8'h01, 8'h02: begin
              rw_d    = (read_data[31:24] == 8'h01);
              dev_d   = read_data[23:16];
              reg_d   = read_data[15:8];
              wdata_d = (read_data[31:24] == 8'h02) ? read_data[7:0] : 8'h00;
              state_d = StIssue;
            end
            default: begin
              fault_code_d = 4'd2;
              state_d      = StFault;
            end
          endcase
        end
      end
      StIssue: if (i2c_ready) state_d = StWaitDone;
      StWaitDone: begin
        if (i2c_done) begin
          if (i2c_ack_err) begin
            fault_code_d = 4'd3;
            state_d      = StFault;
          end else begin
            advance = 1'b1;
            if (rw_q) begin
              rd_valid_d = 1'b1;
              rd_data_d  = i2c_rdata;
            end
          end
        end else if (tmo_hit) begin
          fault_code_d = 4'd4;
          state_d      = StFault;
        end
      end
      default: state_d = StIdle;
    endcase
    // pc stops at the last instruction; it never wraps within a run.
    if (advance) begin
      if (pc_q == LastPc) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      rw_q         <= 1'b0;
      dev_q        <= 8'h00;
      reg_q        <= 8'h00;
      wdata_q      <= 8'h00;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      fault_code_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rw_q         <= rw_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign reg_addr   = pc_q;
  assign i2c_valid  = (state_q == StIssue);
  assign i2c_rw     = rw_q;
  assign i2c_dev    = dev_q;
  assign i2c_reg    = reg_q;
  assign i2c_wdata  = wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q == StFetch) || (state_q == StDecode) ||
                      (state_q == StIssue) || (state_q == StWaitDone);
  assign done       = done_q;
  assign fault      = (state_q == StFault);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: scenario table plus hand-written reset/busy/timeout cases.
// Define SEQ_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  reg_addr;
  logic [31:0] read_data = '0;
  logic [3:0]  error_code = '0;
  logic        i2c_valid, i2c_ready = 1'b0;
  logic        i2c_rw;
  logic [7:0]  i2c_dev, i2c_reg, i2c_wdata;
  logic        i2c_done = 1'b0, i2c_ack_err = 1'b0;
  logic [7:0]  i2c_rdata = 8'h5A;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        busy, done, fault;
  logic [3:0]  fault_code;

  instr_sequencer #(.ADDR_W(8), .PROG_LEN(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reg_addr(reg_addr),
    .read_data(read_data), .error_code(error_code), .i2c_valid(i2c_valid),
    .i2c_ready(i2c_ready), .i2c_rw(i2c_rw), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg),
    .i2c_wdata(i2c_wdata), .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .i2c_rdata(i2c_rdata), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .done(done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Environment state (memory, I2C responder, monitors)
  logic [31:0] mem [2];
  int          err_pc = -1;
  int          rdy_dly = 0;
  bit          nack_wr = 1'b0;
  bit          no_done = 1'b0;
  int          acc_cnt, rd_cnt, done_cnt, stall_cnt, stab_err, pend, stall;
  int          cyc, acc_cyc, fault_cyc;
  logic [7:0]  rd_last;
  logic [24:0] req_log [4];
  logic [24:0] prev_fields;
  bit          prev_stall, last_rw, fault_prev;

  task automatic clear_env();
    acc_cnt = 0; rd_cnt = 0; done_cnt = 0; stall_cnt = 0; stab_err = 0;
    rd_last = 8'h00; acc_cyc = 0; fault_cyc = 0;
    for (int i = 0; i < 4; i++) req_log[i] = '0;
  endtask

  // Everything the environment drives changes on negedge; the DUT samples on posedge.
  always @(negedge clk) begin
    logic [24:0] cur;
    cyc++;
    read_data  = (reg_addr < 8'd2) ? mem[reg_addr[0]] : 32'h0;
    error_code = (int'(reg_addr) == err_pc) ? 4'd1 : 4'd0;
    if (!reset_n) begin
      i2c_ready = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0;
      pend = 0; stall = 0; prev_stall = 1'b0;
    end else begin
      i2c_done = 1'b0; i2c_ack_err = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !no_done) begin
          i2c_done    = 1'b1;
          i2c_ack_err = nack_wr && !last_rw;
        end
      end
      if (i2c_valid) begin
        cur = {i2c_rw, i2c_dev, i2c_reg, i2c_wdata};
        if (prev_stall && cur != prev_fields) stab_err++;
        prev_fields = cur;
        if (stall >= rdy_dly) begin
          i2c_ready = 1'b1;
          if (acc_cnt < 4) req_log[acc_cnt] = cur;
          acc_cnt++;
          acc_cyc = cyc;
          last_rw = i2c_rw;
          pend = 3; stall = 0; prev_stall = 1'b0;
        end else begin
          i2c_ready = 1'b0;
          stall++; stall_cnt++; prev_stall = 1'b1;
        end
      end else begin
        if (prev_stall) stab_err++;
        i2c_ready = 1'b0; prev_stall = 1'b0;
      end
    end
    if (rd_valid) begin rd_cnt++; rd_last = rd_data; end
    if (done) done_cnt++;
    if (fault && !fault_prev) fault_cyc = cyc;
    fault_prev = fault;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] w0, w1;
    int          err_pc, rdy_dly;
    bit          nack;
    int          exp_acc, exp_rd;
    logic [7:0]  exp_rdv;
    int          exp_done, exp_stalls;
    bit          exp_fault;
    logic [3:0]  exp_code;
    logic [16:0] exp_req0;  // {rw, dev, reg} of first request
    logic [24:0] exp_req1;  // {rw, dev, reg, wdata} of second request
  } vec_t;

  vec_t vecs [7];

  initial begin
    //          w0            w1        err rdy nack acc rd rdv  dn stl flt code req0 req1
    vecs[0] = '{32'h0100f000, 32'h021dab32, -1, 0, 0, 2, 1, 8'h5A, 1, 0, 0, 4'd0,
                {1'b1, 8'h00, 8'hF0}, {1'b0, 8'h1D, 8'hAB, 8'h32}};
    vecs[1] = '{32'h0100f000, 32'h021dab32, -1, 5, 0, 2, 1, 8'h5A, 1, 10, 0, 4'd0,
                {1'b1, 8'h00, 8'hF0}, {1'b0, 8'h1D, 8'hAB, 8'h32}};
    vecs[2] = '{32'h0100f000, 32'h021dab32, 1, 0, 0, 1, 1, 8'h5A, 0, 0, 1, 4'd1,
                {1'b1, 8'h00, 8'hF0}, '0};
    vecs[3] = '{32'h07000000, 32'h021dab32, -1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 4'd2, '0, '0};
    vecs[4] = '{32'h0100f000, 32'h021dab32, -1, 0, 1, 2, 1, 8'h5A, 0, 0, 1, 4'd3,
                {1'b1, 8'h00, 8'hF0}, {1'b0, 8'h1D, 8'hAB, 8'h32}};
    vecs[5] = '{32'h00000000, 32'h00ffffff, -1, 0, 0, 0, 0, 8'h00, 1, 0, 0, 4'd0, '0, '0};
    vecs[6] = '{32'h0100f000, 32'h021dab32, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 4'd1, '0, '0};

    mem[0] = 32'h0; mem[1] = 32'h0;
    clear_env();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, i2c_valid}, 32'd0);
    check("rst_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_fault", {27'd0, fault, fault_code}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      mem[0] = vecs[v].w0; mem[1] = vecs[v].w1;
      err_pc = vecs[v].err_pc; rdy_dly = vecs[v].rdy_dly; nack_wr = vecs[v].nack;
      clear_env();
      pulse_start();
      wait_idle(200);
      check($sformatf("v%0d_accepts", v), acc_cnt, vecs[v].exp_acc);
      check($sformatf("v%0d_rd_cnt", v), rd_cnt, vecs[v].exp_rd);
      if (vecs[v].exp_rd > 0) check($sformatf("v%0d_rd_data", v), {24'd0, rd_last},
                                    {24'd0, vecs[v].exp_rdv});
      check($sformatf("v%0d_done", v), done_cnt, vecs[v].exp_done);
      check($sformatf("v%0d_stalls", v), stall_cnt, vecs[v].exp_stalls);
      check($sformatf("v%0d_stable", v), stab_err, 0);
      check($sformatf("v%0d_fault", v), {27'd0, fault, fault_code},
            {27'd0, vecs[v].exp_fault, vecs[v].exp_code});
      if (vecs[v].exp_acc >= 1) check($sformatf("v%0d_req0", v), {15'd0, req_log[0][24:8]},
                                      {15'd0, vecs[v].exp_req0});
      if (vecs[v].exp_acc >= 2) check($sformatf("v%0d_req1", v), {7'd0, req_log[1]},
                                      {7'd0, vecs[v].exp_req1});
    end
    err_pc = -1; rdy_dly = 0; nack_wr = 1'b0;
    mem[0] = 32'h0100f000; mem[1] = 32'h021dab32;

    // start pulsed mid-run must not restart or add a run
    clear_env();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_idle(200);
    check("busy_start_acc", acc_cnt, 2);
    check("busy_start_done", done_cnt, 1);
    check("busy_start_rd", rd_cnt, 1);

    // reset while waiting for completion
    clear_env();
    no_done = 1'b1;
    pulse_start();
    begin
      int n = 0;
      while (acc_cnt < 1 && n < 50) begin @(negedge clk); n++; end
    end
    repeat (2) @(negedge clk);
    check("wait_busy", {31'd0, busy}, 32'd1);
`ifndef SEQ_TIMEOUT_EN
    repeat (40) @(negedge clk);
    check("no_timeout_busy", {31'd0, busy}, 32'd1);
    check("no_timeout_fault", {31'd0, fault}, 32'd0);
`endif
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, i2c_valid}, 32'd0);
    check("arst_fields", {7'd0, i2c_rw, i2c_dev, i2c_reg, i2c_wdata}, 32'd0);
    check("arst_addr", {24'd0, reg_addr}, 32'd0);
    check("arst_status", {22'd0, rd_valid, rd_data, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_acc", acc_cnt, 1);
    check("post_rst_idle", {30'd0, busy, fault}, 32'd0);

`ifdef SEQ_TIMEOUT_EN
    // Accept seen at negedge a; 16 WAIT_DONE cycles follow, fault visible 17 negedges later.
    clear_env();
    pulse_start();
    wait_idle(200);
    check("tmo_fault", {27'd0, fault, fault_code}, {27'd0, 1'b1, 4'd4});
    check("tmo_cycles", fault_cyc - acc_cyc, 17);
`endif
    no_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
